// File: rtl/join_alu.sv
// join_alu: two-operand elastic join feeding a single-entry registered ALU result.
// Latency: one cycle. A pair accepted at edge t is visible on io_dout just after edge t.
// Backpressure: a pair fires only when both operands are present and the output slot
// is empty or unloading. While a result is stalled, both readies are 0.
//
// Ports:
//   clock, reset        rising-edge clock; asynchronous active-low reset
//   io_op, io_const     opcode [3:0] and constant-mode flag [4]; constant operand B
//   io_din_a*/io_din_b* operand streams (data, valid, ready)
//   io_dout*            registered result stream (data, valid, ready)
module join_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4:0]            io_op,
  input  logic [DATA_WIDTH-1:0] io_const,
  input  logic [DATA_WIDTH-1:0] io_din_a,
  input  logic                  io_din_a_v,
  output logic                  io_din_a_r,
  input  logic [DATA_WIDTH-1:0] io_din_b,
  input  logic                  io_din_b_v,
  output logic                  io_din_b_r,
  output logic [DATA_WIDTH-1:0] io_dout,
  output logic                  io_dout_v,
  input  logic                  io_dout_r
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_SRA  = 4'd8,
    OP_SLT  = 4'd9,
    OP_EQ   = 4'd10,
    OP_MIN  = 4'd11,
    OP_MAX  = 4'd12,
    OP_PASS = 4'd13
  } opcode_t;

  logic                  space;
  logic                  b_ok;
  logic                  fire;
  logic                  const_mode;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [4:0]            shamt;
  logic                  lt_signed;
  logic [DATA_WIDTH-1:0] result;

  assign const_mode = io_op[4];
  assign space      = !io_dout_v || io_dout_r;
  assign b_ok       = const_mode || io_din_b_v;

  // Qualifying with reset keeps both readies low while reset is held, so
  // upstream FIFOs never believe a word was taken during reset.
  assign fire       = io_din_a_v && b_ok && space && reset;

  assign io_din_a_r = fire;
  assign io_din_b_r = fire && !const_mode;

  assign op_a      = io_din_a;
  assign op_b      = const_mode ? io_const : io_din_b;
  assign shamt     = op_b[4:0];
  assign lt_signed = $signed(op_a) < $signed(op_b);

  always_comb begin
    result = '0;
    case (opcode_t'(io_op[3:0]))
      OP_ADD:  result = op_a + op_b;
      OP_SUB:  result = op_a - op_b;
      OP_MUL:  result = op_a * op_b;
      OP_AND:  result = op_a & op_b;
      OP_OR:   result = op_a | op_b;
      OP_XOR:  result = op_a ^ op_b;
      OP_SHL:  result = op_a << shamt;
      OP_SHR:  result = op_a >> shamt;
      OP_SRA:  result = $unsigned($signed(op_a) >>> shamt);
      OP_SLT:  result[0] = lt_signed;
      OP_EQ:   result[0] = (op_a == op_b);
      OP_MIN:  result = lt_signed ? op_a : op_b;
      OP_MAX:  result = lt_signed ? op_b : op_a;
      OP_PASS: result = op_a;
      default: result = '0;  // opcodes 14 and 15 are reserved
    endcase
  end

  // Fire has priority over unload: a fire and an unload at the same edge
  // replaces the result and keeps io_dout_v high. A plain unload keeps the
  // last data on io_dout.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_dout   <= '0;
      io_dout_v <= 1'b0;
    end else if (fire) begin
      io_dout   <= result;
      io_dout_v <= 1'b1;
    end else if (io_dout_v && io_dout_r) begin
      io_dout_v <= 1'b0;
    end
  end

endmodule
